// File: rtl/store_buffer.sv
// ---------------------------------------------------------------------------
// store_buffer
//   Posted-write buffer between the core M stage and a slower data-memory
//   port. Stores are accepted one per cycle into a circular FIFO and drained
//   in order over a valid/ready handshake. Optional store-to-load forwarding
//   is built when the macro STORE_BUFFER_FWD_EN is defined.
//
// Parameters
//   DEPTH  number of entries (power of two, >= 2)
//   AW     address width
//   DW     data width
//
// Ports
//   clk         in   system clock, rising edge
//   reset       in   asynchronous active-low reset
//   MemWriteM   in   store request from the M stage
//   ALUOutM     in   store byte address
//   WriteDataM  in   store data
//   full        out  count == DEPTH (registered)
//   empty       out  count == 0 (registered)
//   count       out  occupied entries (registered)
//   overflow    out  sticky flag: a store was dropped (registered)
//   mem_valid   out  head entry presented to memory
//   mem_addr    out  head address
//   mem_wdata   out  head data
//   mem_ready   in   memory accepts the head entry this cycle
//   ld_addr     in   M-stage load address for forwarding lookup
//   ld_hit      out  ld_addr word matches a buffered store
//   ld_data     out  data of youngest matching store
//
// Configuration macro
//   STORE_BUFFER_FWD_EN  defined: forwarding comparators built;
//                        undefined: ld_hit = 0, ld_data = 0, ld_addr ignored.
// ---------------------------------------------------------------------------
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       MemWriteM,
  input  logic [AW-1:0]              ALUOutM,
  input  logic [DW-1:0]              WriteDataM,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       mem_valid,
  output logic [AW-1:0]              mem_addr,
  output logic [DW-1:0]              mem_wdata,
  input  logic                       mem_ready,
  input  logic [AW-1:0]              ld_addr,
  output logic                       ld_hit,
  output logic [DW-1:0]              ld_data
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Entry storage is deliberately left out of reset: occupancy is tracked
  // by head/tail/count, so stale contents are never observed.
  logic [AW-1:0] addr_mem_r [DEPTH];
  logic [DW-1:0] data_mem_r [DEPTH];

  logic [PW-1:0] head_r;
  logic [PW-1:0] tail_r;
  logic [CW-1:0] count_r;
  logic          full_r;
  logic          empty_r;
  logic          overflow_r;

  logic          pop_s;
  logic          push_s;
  logic          drop_s;
  logic [CW-1:0] count_nxt_s;
  logic          ld_hit_s;
  logic [DW-1:0] ld_data_s;
  logic          unused_s;

  // Handshake decode; a full buffer still accepts a store when the head pops
  // in the same cycle, which keeps the mem_ready -> acceptance path combinational.
  always_comb begin
    pop_s  = mem_valid && mem_ready;
    push_s = MemWriteM && (!full_r || pop_s);
    drop_s = MemWriteM && full_r && !pop_s;
  end

  // Next occupancy from the push/pop pair.
  always_comb begin
    count_nxt_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CW'(1);
      2'b01:   count_nxt_s = count_r - CW'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Pointer, occupancy and status registers; full/empty are precomputed so
  // the status outputs come straight from flops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_r     <= '0;
      tail_r     <= '0;
      count_r    <= '0;
      full_r     <= 1'b0;
      empty_r    <= 1'b1;
      overflow_r <= 1'b0;
    end else begin
      if (push_s) begin
        tail_r <= tail_r + PW'(1);
      end else begin
        tail_r <= tail_r;
      end
      if (pop_s) begin
        head_r <= head_r + PW'(1);
      end else begin
        head_r <= head_r;
      end
      count_r    <= count_nxt_s;
      full_r     <= (count_nxt_s == CW'(DEPTH));
      empty_r    <= (count_nxt_s == CW'(0));
      overflow_r <= overflow_r || drop_s;
    end
  end

  // Entry array write at the tail.
  always_ff @(posedge clk) begin
    if (push_s) begin
      addr_mem_r[tail_r] <= ALUOutM;
      data_mem_r[tail_r] <= WriteDataM;
    end
  end

`ifdef STORE_BUFFER_FWD_EN
  // Word-granular lookup over occupied entries, walked oldest to youngest so
  // the youngest match is the one left standing. The entry at head still
  // participates even if it pops this cycle; an incoming store does not,
  // because it is not in the array until the edge.
  always_comb begin
    logic [PW-1:0] idx;
    ld_hit_s  = 1'b0;
    ld_data_s = {DW{1'b0}};
    idx       = head_r;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_r + i[PW-1:0];
      if ((CW'(i) < count_r) && (addr_mem_r[idx][AW-1:2] == ld_addr[AW-1:2])) begin
        ld_hit_s  = 1'b1;
        ld_data_s = data_mem_r[idx];
      end else begin
        ld_hit_s  = ld_hit_s;
        ld_data_s = ld_data_s;
      end
    end
  end

  assign unused_s = ^ld_addr[1:0];
`else
  // Forwarding not built: outputs tied off and the lookup address ignored.
  always_comb begin
    ld_hit_s  = 1'b0;
    ld_data_s = {DW{1'b0}};
  end

  assign unused_s = ^ld_addr;
`endif

  assign full      = full_r;
  assign empty     = empty_r;
  assign count     = count_r;
  assign overflow  = overflow_r;
  assign mem_valid = !empty_r;
  assign mem_addr  = addr_mem_r[head_r];
  assign mem_wdata = data_mem_r[head_r];
  assign ld_hit    = ld_hit_s;
  assign ld_data   = ld_data_s;

endmodule

// File: doc/store_buffer.md
# store_buffer

Posted-write buffer between the pipelined core's memory stage and a slower data-memory port. It accepts one store per cycle from the M-stage bus (MemWriteM, ALUOutM, WriteDataM) without stalling the core. Stores are queued in a circular FIFO and drained in order over a valid/ready handshake, so store latency is hidden from the pipeline. Optionally, it forwards buffered store data to M-stage loads.

## Interface
Parameters:
- DEPTH, 4, number of entries; power of two, ≥2
- AW, 32, address width
- DW, 32, data width

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately
- MemWriteM  in  1  store request from the M stage
- ALUOutM  in  AW  store address (byte address)
- WriteDataM  in  DW  store data
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- count  out  $clog2(DEPTH)+1  occupied entries
- overflow  out  1  sticky error: a store was dropped
- mem_valid  out  1  head entry presented to memory
- mem_addr  out  AW  head address
- mem_wdata  out  DW  head data
- mem_ready  in  1  memory accepts head this cycle
- ld_addr  in  AW  M-stage load address for forwarding lookup
- ld_hit  out  1  ld_addr matches a buffered store
- ld_data  out  DW  data of youngest matching store

## Operation
- State: DEPTH×(AW+DW) entry array, head and tail pointers (log2 DEPTH bits, wrap mod DEPTH), count register, overflow flag.
- pop = mem_valid && mem_ready.
- push = MemWriteM && (!full || pop). A push into a full buffer is legal when a pop occurs in the same cycle.
- A dropped store (MemWriteM && full && !pop) sets overflow. The store is discarded, and overflow holds until reset.
- On push: entry[tail] is written and tail increments. On pop: head increments.
- count changes as follows: push only → count+1; pop only → count−1; both → unchanged.
- mem_valid = !empty. mem_addr and mem_wdata are taken from entry[head]. They are stable while mem_valid && !mem_ready.
- Ordering is strictly FIFO, with no coalescing or merging of stores to the same address.
- Forwarding (macro enabled):
  - Combinational compare of ld_addr[AW-1:2] against every occupied entry's address[AW-1:2].
  - The youngest match (closest to tail) wins and drives ld_hit = 1 and ld_data.
  - An entry popping this cycle still participates in the compare.
  - A store pushing this cycle does not participate.
- Reset (async, active-low) sets head = tail = 0, count = 0, overflow = 0. The entry array is not cleared.
- Reset asserted mid-drain abandons all queued stores, and mem_valid drops immediately.

## Timing
- Reset values: full = 0, empty = 1, count = 0, overflow = 0, mem_valid = 0, ld_hit = 0. mem_addr, mem_wdata and ld_data are don't-care while their qualifier is low.
- Latency: a store accepted at edge N appears on mem_valid during cycle N+1 if the buffer was empty.
- Throughput: one push and one pop per cycle sustained.
- Status outputs: full, empty, count and overflow are registered and change only on clock edges or reset.
- Combinational paths: mem_ready → push acceptance, and ld_addr → ld_hit/ld_data.
- No combinational path from MemWriteM to any output.

## Configuration
- STORE_BUFFER_FWD_EN:
  - Defined: the forwarding comparators and priority select are built as described above.
  - Undefined: no comparators are synthesized. ld_hit is tied to 0, ld_data is tied to 0, and ld_addr is ignored. Port list is unchanged.

## Test plan
- Reset then idle: after reset release, empty = 1, count = 0, mem_valid = 0, overflow = 0.
- Single store, memory ready:
  - Stimulus: push addr 0x10, data 0xDEADBEEF at edge 1, with mem_ready held high.
  - Response: mem_valid = 1 with 0x10/0xDEADBEEF during cycle 2; empty = 1 after edge 2.
- Fill and overflow:
  - Stimulus: DEPTH = 4, mem_ready = 0, five consecutive stores to 0x0, 0x4, 0x8, 0xC, 0x10.
  - Response: full = 1 after the 4th store; overflow = 1 after the 5th. Draining yields 0x0, 0x4, 0x8, 0xC in order; 0x10 is never presented.
- Push while full with simultaneous pop:
  - Stimulus: buffer full, MemWriteM = 1 and mem_ready = 1 in the same cycle.
  - Response: count stays 4, overflow stays 0, and the new store appears last in drain order.
- Pointer wrap: with mem_ready toggling every other cycle, 20 sequential stores all drain in order with matching addr/data through multiple pointer wraps.
- Forwarding (macro defined):
  - Stimulus: buffer holds 0x20 → 0x1111 then 0x20 → 0x2222; ld_addr = 0x22.
  - Response: ld_hit = 1, ld_data = 0x2222. With ld_addr = 0x40, ld_hit = 0. With the macro undefined, ld_hit = 0 in all cases.
